// File: rtl/i2d_wbarb_pkg.sv
// i2d_wbarb_pkg: shared arbiter state encoding, timeout default and the
// round-robin pick function used by the two-master Wishbone arbiter.
package i2d_wbarb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_e;

  localparam int unsigned TMO_DEF = 255;

  // Round-robin choice: a lone requester wins, a tie goes to the master
  // that was not served last, no request parks the bus.
  function automatic arb_state_e arb_pick(input logic req0, input logic req1,
                                          input logic last);
    arb_state_e pick;
    pick = ARB_IDLE;
    if (req0 && req1) begin
      pick = last ? ARB_GNT0 : ARB_GNT1;
    end else if (req0) begin
      pick = ARB_GNT0;
    end else if (req1) begin
      pick = ARB_GNT1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/i2d_wbarb_tmo.sv
// i2d_wbarb_tmo: 8-bit slave-response watchdog. Counts granted cycles with
// an active cycle and no slave response; flags a hit when the count reaches
// the limit and restarts from zero.
module i2d_wbarb_tmo
  import i2d_wbarb_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,   // grant is changing this cycle
  input  logic run_i,   // granted master has cyc asserted
  input  logic resp_i,  // any of ack/err/retry from the slave
  output logic hit_o
);

  localparam logic [7:0] LIM = TMO[7:0];

  logic [7:0] cnt_q, cnt_d;

  assign hit_o = run_i && (cnt_q == LIM);

  // Next count: clear on grant change, response or timeout, else count busy cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || resp_i || hit_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2d_wbarb.sv
// i2d_wbarb: two-master (m0 = IFU, m1 = MAU) to one-slave Wishbone arbiter
// with round-robin fairness and registered grant. Optional slave-response
// timeout is enabled by defining I2D_WBARB_TIMEOUT_EN.
module i2d_wbarb
  import i2d_wbarb_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_try_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_try_o,
  output logic [AW-1:0]   adr_o,
  output logic [DW-1:0]   dat_o,
  output logic [DW/8-1:0] sel_o,
  output logic            we_o,
  output logic            cyc_o,
  input  logic [DW-1:0]   dat_i,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic            try_i,
  output logic [1:0]      gnt_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       tmo_hit;

  assign gnt_o = state_q;

  // Next grant: arbitrate from IDLE or once the granted master releases cyc.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: state_d = arb_pick(m0_cyc_i, m1_cyc_i, last_q);
      ARB_GNT0: begin
        if (!m0_cyc_i) begin
          state_d = arb_pick(1'b0, m1_cyc_i, 1'b0);
          last_d  = 1'b0;
        end
      end
      ARB_GNT1: begin
        if (!m1_cyc_i) begin
          state_d = arb_pick(m0_cyc_i, 1'b0, 1'b1);
          last_d  = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant state and last-served pointer; async reset drops the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Bus mux toward the slave and response routing to the granted master only.
  always_comb begin
    adr_o    = '0;
    dat_o    = '0;
    sel_o    = '0;
    we_o     = 1'b0;
    cyc_o    = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_try_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_try_o = 1'b0;
    unique case (state_q)
      ARB_GNT0: begin
        adr_o    = m0_adr_i;
        dat_o    = m0_dat_i;
        sel_o    = m0_sel_i;
        we_o     = m0_we_i;
        cyc_o    = m0_cyc_i && !tmo_hit;
        m0_dat_o = dat_i;
        m0_ack_o = ack_i;
        m0_err_o = err_i || tmo_hit;
        m0_try_o = try_i;
      end
      ARB_GNT1: begin
        adr_o    = m1_adr_i;
        dat_o    = m1_dat_i;
        sel_o    = m1_sel_i;
        we_o     = m1_we_i;
        cyc_o    = m1_cyc_i && !tmo_hit;
        m1_dat_o = dat_i;
        m1_ack_o = ack_i;
        m1_err_o = err_i || tmo_hit;
        m1_try_o = try_i;
      end
      default: ;
    endcase
  end

`ifdef I2D_WBARB_TIMEOUT_EN
  logic tmo_run;

  // Granted master's own cyc, before any timeout masking.
  always_comb begin
    tmo_run = 1'b0;
    if (state_q == ARB_GNT0) tmo_run = m0_cyc_i;
    if (state_q == ARB_GNT1) tmo_run = m1_cyc_i;
  end

  i2d_wbarb_tmo #(
    .TMO(TMO)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_d != state_q),
    .run_i (tmo_run),
    .resp_i(ack_i || err_i || try_i),
    .hit_o (tmo_hit)
  );
`else
  logic unused_tmo_par;
  assign unused_tmo_par = ^TMO;
  assign tmo_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_i2d_wbarb.sv
// tb_i2d_wbarb: scoreboard-based bench for the two-master Wishbone arbiter.
module tb_i2d_wbarb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_adr_i, m1_adr_i, adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, dat_o, dat_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i, sel_o;
  logic          m0_we_i, m0_cyc_i, m0_ack_o, m0_err_o, m0_try_o;
  logic          m1_we_i, m1_cyc_i, m1_ack_o, m1_err_o, m1_try_o;
  logic          we_o, cyc_o, ack_i, err_i, try_i;
  logic [1:0]    gnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [1:0]    gnt;
    logic [AW-1:0] adr;
    logic [DW-1:0] rdat;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  i2d_wbarb #(
    .AW (AW),
    .DW (DW),
    .TMO(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i),
    .m0_sel_i(m0_sel_i),
    .m0_we_i (m0_we_i),
    .m0_cyc_i(m0_cyc_i),
    .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m0_try_o(m0_try_o),
    .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i),
    .m1_sel_i(m1_sel_i),
    .m1_we_i (m1_we_i),
    .m1_cyc_i(m1_cyc_i),
    .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .m1_try_o(m1_try_o),
    .adr_o   (adr_o),
    .dat_o   (dat_o),
    .sel_o   (sel_o),
    .we_o    (we_o),
    .cyc_o   (cyc_o),
    .dat_i   (dat_i),
    .ack_i   (ack_i),
    .err_i   (err_i),
    .try_i   (try_i),
    .gnt_o   (gnt_o)
  );

  task automatic idle_inputs();
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0;
    dat_i = '0; ack_i = 1'b0; err_i = 1'b0; try_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    m0_cyc_i = 1'b1; m0_adr_i = 32'h44; ack_i = 1'b1; err_i = 1'b1; try_i = 1'b1;
    dat_i = 32'hDEAD_BEEF;
    @(negedge clk); #2;
    checks++;
    if (gnt_o !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got %b exp 00", gnt_o);
    end
    checks++;
    if ({cyc_o, we_o, adr_o, dat_o, sel_o} !== '0) begin
      errors++; $display("FAIL reset_bus got cyc=%b adr=%h exp all zero", cyc_o, adr_o);
    end
    checks++;
    if ({m0_ack_o, m0_err_o, m0_try_o, m1_ack_o, m1_err_o, m1_try_o, m0_dat_o, m1_dat_o} !== '0) begin
      errors++; $display("FAIL reset_resp got m0ack=%b m0dat=%h exp zero", m0_ack_o, m0_dat_o);
    end
    m0_cyc_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #2;
    checks++;
    if ({gnt_o, m0_ack_o, m0_err_o, m1_ack_o, m1_try_o, m0_dat_o} !== '0) begin
      errors++; $display("FAIL idle_resp got gnt=%b m0ack=%b m1ack=%b exp zero", gnt_o, m0_ack_o, m1_ack_o);
    end
    idle_inputs();
  endtask

  task automatic test_single_m1();
    exp_t e;
    do_reset();
    m1_adr_i = 32'h100; m1_dat_i = 32'hA5A5_0001; m1_sel_i = 4'b0011; m1_we_i = 1'b1;
    m1_cyc_i = 1'b1;
    sbq.push_back('{gnt: 2'b10, adr: 32'h100, rdat: 32'h1234_5678});
    @(negedge clk); #2;
    checks++;
    if (gnt_o !== sbq[0].gnt || cyc_o !== 1'b1 || adr_o !== sbq[0].adr) begin
      errors++; $display("FAIL single_grant got gnt=%b cyc=%b adr=%h exp 10 1 %h", gnt_o, cyc_o, adr_o, sbq[0].adr);
    end
    checks++;
    if (dat_o !== 32'hA5A5_0001 || sel_o !== 4'b0011 || we_o !== 1'b1) begin
      errors++; $display("FAIL single_wr got dat=%h sel=%b we=%b exp a5a50001 0011 1", dat_o, sel_o, we_o);
    end
    @(negedge clk);
    @(negedge clk);
    e = sbq.pop_front();
    ack_i = 1'b1; dat_i = e.rdat;
    #2;
    checks++;
    if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_dat_o !== e.rdat || m0_dat_o !== '0) begin
      errors++; $display("FAIL single_ack got m1ack=%b m0ack=%b m1dat=%h exp 1 0 %h", m1_ack_o, m0_ack_o, m1_dat_o, e.rdat);
    end
    @(negedge clk);
    ack_i = 1'b0; m1_cyc_i = 1'b0;
    #2;
    checks++;
    if (gnt_o !== 2'b10 || cyc_o !== 1'b0) begin
      errors++; $display("FAIL single_drop got gnt=%b cyc=%b exp 10 0", gnt_o, cyc_o);
    end
    @(negedge clk); #2;
    checks++;
    if (gnt_o !== 2'b00) begin
      errors++; $display("FAIL single_idle got gnt=%b exp 00", gnt_o);
    end
    idle_inputs();
  endtask

  task automatic test_both_start();
    exp_t e;
    do_reset();
    sbq.push_back('{gnt: 2'b10, adr: 32'h300, rdat: 32'h0000_0300});
    sbq.push_back('{gnt: 2'b01, adr: 32'h200, rdat: 32'h0000_0200});
    m0_adr_i = 32'h200; m1_adr_i = 32'h300; m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    @(negedge clk); #2;
    e = sbq.pop_front();
    ack_i = 1'b1; dat_i = e.rdat; #1;
    checks++;
    if (gnt_o !== e.gnt || adr_o !== e.adr || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL both_first got gnt=%b adr=%h m1ack=%b exp %b %h 1", gnt_o, adr_o, m1_ack_o, e.gnt, e.adr);
    end
    @(negedge clk);
    ack_i = 1'b0; m1_cyc_i = 1'b0;
    #2;
    checks++;
    if (gnt_o !== 2'b10 || cyc_o !== 1'b0) begin
      errors++; $display("FAIL both_handover got gnt=%b cyc=%b exp 10 0", gnt_o, cyc_o);
    end
    @(negedge clk); #2;
    e = sbq.pop_front();
    checks++;
    if (gnt_o !== e.gnt || adr_o !== e.adr || cyc_o !== 1'b1) begin
      errors++; $display("FAIL both_second got gnt=%b adr=%h exp %b %h", gnt_o, adr_o, e.gnt, e.adr);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   s0, s1, n0, n1, budget;
    logic mlast, pick1, drop0, drop1;
    do_reset();
    s0 = 0; s1 = 0; mlast = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (s0 < 4 && s1 < 4) pick1 = (mlast == 1'b0);
      else pick1 = (s1 < 4);
      if (pick1) begin
        sbq.push_back('{gnt: 2'b10, adr: 32'h2000 + 32'(s1 * 4), rdat: 32'hC0DE_0000 + 32'(i)});
        s1++;
      end else begin
        sbq.push_back('{gnt: 2'b01, adr: 32'h1000 + 32'(s0 * 4), rdat: 32'hC0DE_0000 + 32'(i)});
        s0++;
      end
      mlast = pick1;
    end
    n0 = 0; n1 = 0; budget = 0; drop0 = 1'b0; drop1 = 1'b0;
    while ((n0 < 4 || n1 < 4) && budget < 200) begin
      @(negedge clk);
      budget++;
      ack_i = 1'b0;
      m0_cyc_i = (n0 < 4) && !drop0; m0_adr_i = 32'h1000 + 32'(n0 * 4);
      m1_cyc_i = (n1 < 4) && !drop1; m1_adr_i = 32'h2000 + 32'(n1 * 4);
      drop0 = 1'b0; drop1 = 1'b0;
      #2;
      if (cyc_o === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++; $display("FAIL rr_extra got unexpected cyc_o gnt=%b exp no transfer", gnt_o);
          n0 = 4; n1 = 4;
        end else begin
          e = sbq.pop_front();
          ack_i = 1'b1; dat_i = e.rdat; #1;
          if (gnt_o !== e.gnt || adr_o !== e.adr) begin
            errors++; $display("FAIL rr_grant got gnt=%b adr=%h exp %b %h", gnt_o, adr_o, e.gnt, e.adr);
          end
          checks++;
          if ({m1_ack_o, m0_ack_o} !== e.gnt) begin
            errors++; $display("FAIL rr_ack got %b%b exp %b", m1_ack_o, m0_ack_o, e.gnt);
          end
          checks++;
          if ((e.gnt == 2'b01 && (m0_dat_o !== e.rdat || m1_dat_o !== '0)) ||
              (e.gnt == 2'b10 && (m1_dat_o !== e.rdat || m0_dat_o !== '0))) begin
            errors++; $display("FAIL rr_data got m0=%h m1=%h exp %h to %b", m0_dat_o, m1_dat_o, e.rdat, e.gnt);
          end
          if (e.gnt == 2'b01) begin n0++; drop0 = 1'b1; end
          else begin n1++; drop1 = 1'b1; end
        end
      end
    end
    checks++;
    if (budget >= 200 || sbq.size() != 0) begin
      errors++; $display("FAIL rr_done got budget=%0d left=%0d exp <200 0", budget, sbq.size());
      sbq.delete();
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_no_preempt();
    do_reset();
    m0_cyc_i = 1'b1; m0_adr_i = 32'h400;
    @(negedge clk); #2;
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++; $display("FAIL np_grant got %b exp 01", gnt_o);
    end
    m1_cyc_i = 1'b1; m1_adr_i = 32'h500;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #2;
      checks++;
      if (gnt_o !== 2'b01 || adr_o !== 32'h400) begin
        errors++; $display("FAIL np_hold got gnt=%b adr=%h exp 01 400", gnt_o, adr_o);
      end
    end
    err_i = 1'b1; try_i = 1'b1; #1;
    checks++;
    if ({m0_err_o, m0_try_o, m1_err_o, m1_try_o} !== 4'b1100) begin
      errors++; $display("FAIL np_errtry got %b%b%b%b exp 1100", m0_err_o, m0_try_o, m1_err_o, m1_try_o);
    end
    @(negedge clk);
    err_i = 1'b0; try_i = 1'b0;
    m0_cyc_i = 1'b0; ack_i = 1'b1; dat_i = 32'h0BAD_F00D;
    #2;
    checks++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m0_dat_o !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL np_lastack got m0ack=%b m1ack=%b dat=%h exp 1 0 0badf00d", m0_ack_o, m1_ack_o, m0_dat_o);
    end
    @(negedge clk);
    ack_i = 1'b0; #2;
    checks++;
    if (gnt_o !== 2'b10 || adr_o !== 32'h500) begin
      errors++; $display("FAIL np_switch got gnt=%b adr=%h exp 10 500", gnt_o, adr_o);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc_i = 1'b1; m1_adr_i = 32'h600;
    @(negedge clk); #2;
    checks++;
    if (cyc_o !== 1'b1) begin
      errors++; $display("FAIL rm_pre got cyc=%b exp 1", cyc_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cyc_o !== 1'b0 || gnt_o !== 2'b00 || adr_o !== '0) begin
      errors++; $display("FAIL rm_async got cyc=%b gnt=%b exp 0 00", cyc_o, gnt_o);
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_timeout();
    logic exp_err;
    do_reset();
    m0_cyc_i = 1'b1; m0_adr_i = 32'h700;
`ifdef I2D_WBARB_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #2;
      exp_err = (k == 5);
      checks++;
      if (m0_err_o !== exp_err || cyc_o !== !exp_err || gnt_o !== 2'b01 || m1_err_o !== 1'b0) begin
        errors++; $display("FAIL tmo_cycle%0d got err=%b cyc=%b gnt=%b exp %b %b 01", k, m0_err_o, cyc_o, gnt_o, exp_err, !exp_err);
      end
    end
`else
    exp_err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #2;
      checks++;
      if (m0_err_o !== exp_err || cyc_o !== 1'b1 || gnt_o !== 2'b01) begin
        errors++; $display("FAIL hang_cycle%0d got err=%b cyc=%b gnt=%b exp 0 1 01", k, m0_err_o, cyc_o, gnt_o);
      end
    end
`endif
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_m1();
    test_both_start();
    test_round_robin();
    test_no_preempt();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
